// File: rtl/fp8_dot_mac_pkg.sv
// Shared types and FP8 decode for the FP8 dot-product MAC column element.
// All products are aligned onto a fixed-point grid whose LSB weight is 2^-32.
package fp8_mac_pkg;

    typedef enum logic {E4M3 = 1'b0, E5M2 = 1'b1} fmt_e;

    typedef enum logic [1:0] {S_ACC, S_FLUSH, S_WAIT_OUT} state_e;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_NINF = 16'hFF80;

    localparam int E4M3_BIAS = 7;
    localparam int E4M3_EMIN = -6;
    localparam int E5M2_BIAS = 15;
    localparam int E5M2_EMIN = -14;
    localparam int GRID_FRAC = 32;
    localparam int PROD_W    = 65;

    typedef struct packed {
        logic             sign;
        logic [3:0]       sig;
        logic [6:0]       exp_eff;
        logic             is_nan;
        logic             is_inf;
        logic             is_zero;
    } fp8_t;

    // sig always carries 3 fraction bits; E5M2 pads its 2-bit mantissa with a zero
    function automatic fp8_t fp8_decode(input logic [7:0] v, input fmt_e fmt);
        fp8_t d;
        d = '0;
        d.sign    = v[7];
        d.is_zero = (v[6:0] == 7'd0);
        if (fmt == E4M3) begin
            d.sig     = {(v[6:3] != 4'd0), v[2:0]};
            d.exp_eff = (v[6:3] == 4'd0) ? 7'(E4M3_EMIN) : 7'({3'b000, v[6:3]}) - 7'(E4M3_BIAS);
            d.is_nan  = (v[6:0] == 7'h7F);
        end else begin
            d.sig     = {(v[6:2] != 5'd0), v[1:0], 1'b0};
            d.exp_eff = (v[6:2] == 5'd0) ? 7'(E5M2_EMIN) : 7'({2'b00, v[6:2]}) - 7'(E5M2_BIAS);
            d.is_inf  = (v[6:2] == 5'd31) && (v[1:0] == 2'd0);
            d.is_nan  = (v[6:2] == 5'd31) && (v[1:0] != 2'd0);
        end
        return d;
    endfunction

endpackage

// File: rtl/fp8_dot_mac_if.sv
// Operand/result bus of one fp8_dot_mac column element.
interface fp8_dot_mac_if #(parameter int LANES = 2);
    logic                 mode_fp8;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [LANES*8-1:0]   a_in;
    logic [LANES*8-1:0]   b_in;
    logic [LANES*8-1:0]   a_out;
    logic                 a_valid_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_data;
    logic [1:0]           out_flags;

    modport master (
        output mode_fp8, in_valid, in_last, a_in, b_in, out_ready,
        input  in_ready, a_out, a_valid_out, out_valid, out_data, out_flags
    );

    modport slave (
        input  mode_fp8, in_valid, in_last, a_in, b_in, out_ready,
        output in_ready, a_out, a_valid_out, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp8_dot_mac_lane_mul.sv
// One lane: decode both FP8 operands, multiply significands and align the
// signed product onto the 2^-32 grid. Specials yield a zero product plus flags.
module fp8_lane_mul
    import fp8_mac_pkg::*;
(
    input  logic [7:0]                  a,
    input  logic [7:0]                  b,
    input  fmt_e                        fmt,
    output logic signed [PROD_W-1:0]    prod,
    output logic                        is_nan,
    output logic                        is_inf,
    output logic                        inf_neg
);
    fp8_t              da, db;
    logic [7:0]        sig_p;
    logic signed [7:0] ea, eb, shamt;
    logic [63:0]       mag;

    always_comb begin
        da      = fp8_decode(a, fmt);
        db      = fp8_decode(b, fmt);
        sig_p   = 8'(da.sig) * 8'(db.sig);
        ea      = {da.exp_eff[6], da.exp_eff};
        eb      = {db.exp_eff[6], db.exp_eff};
        // value = sig_p * 2^(ea+eb-6); grid offset 32 gives shift ea+eb+26
        shamt   = ea + eb + 8'sd26;
        is_nan  = da.is_nan | db.is_nan | (da.is_inf & db.is_zero) | (da.is_zero & db.is_inf);
        is_inf  = (da.is_inf | db.is_inf) & ~is_nan;
        inf_neg = da.sign ^ db.sign;
        mag     = '0;
        if (!(is_nan || is_inf)) begin
            // negative shifts only occur for E5M2 subnormals, whose products end in 2 zero bits
            if (shamt < 0) mag = {56'd0, sig_p} >> (-shamt);
            else           mag = {56'd0, sig_p} << shamt;
        end
        prod = PROD_W'(mag);
        if (da.sign ^ db.sign) prod = -prod;
    end
endmodule

// File: rtl/fp8_dot_mac.sv
// FP8 dot-product MAC column element: LANES products per beat, exact fixed-point
// accumulation over a group, BF16 result through a ready/valid output register.
//   state      | meaning
//   S_ACC      | accepting beats, counting toward DEPTH
//   S_FLUSH    | two cycles while product and accumulate stages drain
//   S_WAIT_OUT | result ready; load output register once it is free
module fp8_dot_mac
    import fp8_mac_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int ACC_W = 80
) (
    input  logic          clk,
    input  logic          rst,
    fp8_dot_mac_if.slave  bus
);
    localparam int CW = $clog2(DEPTH);
    localparam int LW = $clog2(ACC_W);

    if (ACC_W < PROD_W + $clog2(LANES * DEPTH)) begin : g_acc_w_check
        $error("fp8_dot_mac: ACC_W too narrow for LANES*DEPTH products");
    end

    state_e                    state, state_nx;
    logic                      flush_cnt, alive, in_ready_c, accept, close, load;
    logic [CW-1:0]             cnt;
    fmt_e                      mode_q, mode_cur;
    logic signed [PROD_W-1:0]  prod [LANES];
    logic [LANES-1:0]          l_nan, l_inf, l_neg;
    logic signed [ACC_W-1:0]   lane_sum, p_sum, acc;
    logic                      p_valid, p_nan, p_pinf, p_ninf;
    logic                      acc_nan, acc_pinf, acc_ninf;
    logic [LANES*8-1:0]        a_out_q;
    logic                      a_valid_q, out_valid_q;
    logic [15:0]               out_data_q, conv_data;
    logic [1:0]                out_flags_q, conv_flags;
    logic [ACC_W-1:0]          mag, norm;
    logic [LW-1:0]             lead;
    logic [7:0]                exp_b;
    logic [6:0]                man;
    logic                      guard, sticky, rnd;
    logic [14:0]               em;

    assign in_ready_c = alive && (state == S_ACC);
    assign accept     = bus.in_valid && in_ready_c;
    assign close      = accept && (bus.in_last || (cnt == CW'(DEPTH - 1)));
    assign load       = (state == S_WAIT_OUT) && (!out_valid_q || bus.out_ready);
    assign mode_cur   = (cnt == '0) ? fmt_e'(bus.mode_fp8) : mode_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp8_lane_mul u_mul (
            .a       (bus.a_in[8*i +: 8]),
            .b       (bus.b_in[8*i +: 8]),
            .fmt     (mode_cur),
            .prod    (prod[i]),
            .is_nan  (l_nan[i]),
            .is_inf  (l_inf[i]),
            .inf_neg (l_neg[i])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_ACC:      if (close)     state_nx = S_FLUSH;
            S_FLUSH:    if (flush_cnt) state_nx = S_WAIT_OUT;
            S_WAIT_OUT: if (load)      state_nx = S_ACC;
            default:                   state_nx = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACC;
            flush_cnt <= 1'b0;
            alive     <= 1'b0;
        end else begin
            state     <= state_nx;
            flush_cnt <= (state == S_FLUSH) && !flush_cnt;
            alive     <= 1'b1;
        end
    end

    // Leading-one detect and round-to-nearest-even onto an 8-bit significand
    always_comb begin
        mag  = acc[ACC_W-1] ? $unsigned(-acc) : $unsigned(acc);
        lead = '0;
        for (int i = 0; i < ACC_W; i++)
            if (mag[i]) lead = LW'(i);
        norm   = mag << (ACC_W - 1 - int'(lead));
        man    = norm[ACC_W-2 -: 7];
        guard  = norm[ACC_W-9];
        sticky = |norm[ACC_W-10:0];
        rnd    = guard & (sticky | man[0]);
        exp_b  = 8'(lead) + 8'd95;
        em     = {exp_b, man} + 15'(rnd);
        if (acc_nan || (acc_pinf && acc_ninf)) begin
            conv_data  = BF16_QNAN;
            conv_flags = 2'b10;
        end else if (acc_pinf || acc_ninf) begin
            conv_data  = acc_pinf ? BF16_PINF : BF16_NINF;
            conv_flags = 2'b01;
        end else if (acc == '0) begin
            conv_data  = 16'h0000;
            conv_flags = 2'b00;
        end else begin
            conv_data  = {acc[ACC_W-1], em};
            conv_flags = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            mode_q      <= E4M3;
            a_out_q     <= '0;
            a_valid_q   <= 1'b0;
            p_valid     <= 1'b0;
            p_sum       <= '0;
            p_nan       <= 1'b0;
            p_pinf      <= 1'b0;
            p_ninf      <= 1'b0;
            acc         <= '0;
            acc_nan     <= 1'b0;
            acc_pinf    <= 1'b0;
            acc_ninf    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            a_valid_q <= accept;
            if (accept) begin
                a_out_q <= bus.a_in;
                cnt     <= close ? '0 : cnt + 1'b1;
                if (cnt == '0) mode_q <= mode_cur;
            end
            p_valid <= accept;
            p_sum   <= accept ? lane_sum : '0;
            p_nan   <= accept && (|l_nan);
            p_pinf  <= accept && (|(l_inf & ~l_neg));
            p_ninf  <= accept && (|(l_inf & l_neg));
            if (load) begin
                acc      <= '0;
                acc_nan  <= 1'b0;
                acc_pinf <= 1'b0;
                acc_ninf <= 1'b0;
            end else if (p_valid) begin
                acc      <= acc + p_sum;
                acc_nan  <= acc_nan  | p_nan;
                acc_pinf <= acc_pinf | p_pinf;
                acc_ninf <= acc_ninf | p_ninf;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= conv_data;
                out_flags_q <= conv_flags;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.a_out       = a_out_q;
    assign bus.a_valid_out = a_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_flags   = out_flags_q;
endmodule

// File: tb/tb_fp8_dot_mac.sv
// Scoreboard bench for fp8_dot_mac: directed groups push expected BF16 results,
// a negedge monitor compares whatever the DUT presents.
module tb_fp8_dot_mac;
    import fp8_mac_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp8_dot_mac_if #(.LANES(LANES)) bus ();

    fp8_dot_mac #(.LANES(LANES), .DEPTH(DEPTH), .ACC_W(80)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_pulse = 0;
    logic [17:0] exp_q [$];
    logic [15:0] aexp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_res(input logic [15:0] data, input logic [1:0] flags);
        exp_q.push_back({flags, data});
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %h flags %b, want no result", bus.out_data, bus.out_flags);
            end else begin
                check("out_data", 32'(bus.out_data), 32'(exp_q[0][15:0]));
                check("out_flags", 32'(bus.out_flags), 32'(exp_q[0][17:16]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
        if (!rst && bus.a_valid_out) begin
            n_pulse++;
            if (aexp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_a_valid: got a_out %h, want no pulse", bus.a_out);
            end else begin
                check("a_out", 32'(bus.a_out), 32'(aexp_q.pop_front()));
            end
        end
    end

    task automatic beat(input logic mode, input logic [15:0] a, input logic [15:0] b, input logic last);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode_fp8 = mode;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            t++;
            if (t > 100) break;
        end
        if (!ok) begin
            bus.in_valid = 1'b0;
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready 0 for 100 cycles, want 1");
        end
        @(posedge clk);
        #1;
        if (ok) begin
            n_acc++;
            aexp_q.push_back(a);
        end
        bus.in_valid = 1'b0;
        bus.a_in     = 16'($urandom);
        bus.b_in     = 16'($urandom);
        bus.mode_fp8 = 1'($urandom);
        bus.in_last  = 1'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results pending, want 0", exp_q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.mode_fp8  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b1;

        @(posedge clk); #2;
        check("rst_in_ready",  32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data), 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_a_out",     32'(bus.a_out), 32'd0);
        check("rst_a_valid",   32'(bus.a_valid_out), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // E4M3 full group: 4 x (1*2 + 1*2) = 16, latency 3 edges after last accept
        expect_res(16'h4180, 2'b00);
        for (int i = 0; i < DEPTH - 1; i++) beat(1'b0, 16'h3838, 16'h4040, 1'b0);
        beat(1'b0, 16'h3838, 16'h4040, 1'b0);
        check("lat_edge0", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1; check("lat_edge1", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1; check("lat_edge2", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1; check("lat_edge3", 32'(bus.out_valid), 32'd1);
        drain();

        // E5M2 early close, normal and smallest subnormal
        expect_res(16'h3F80, 2'b00); beat(1'b1, 16'h003C, 16'h003C, 1'b1);
        expect_res(16'h2F80, 2'b00); beat(1'b1, 16'h0001, 16'h0001, 1'b1);
        // Specials
        expect_res(16'h7F80, 2'b01); beat(1'b1, 16'h7C3C, 16'h3C3C, 1'b1);
        expect_res(16'hFF80, 2'b01); beat(1'b1, 16'h00FC, 16'h003C, 1'b1);
        expect_res(16'h7FC0, 2'b10); beat(1'b1, 16'h3C00, 16'h3C7C, 1'b1);
        expect_res(16'h7FC0, 2'b10); beat(1'b1, 16'h7CFC, 16'h3C3C, 1'b1);
        expect_res(16'h7FC0, 2'b10); beat(1'b0, 16'h387F, 16'h3838, 1'b1);
        // Cancellation, negative result, rounding tie/up/carry
        expect_res(16'h0000, 2'b00); beat(1'b0, 16'hB838, 16'h3838, 1'b1);
        expect_res(16'hC000, 2'b00); beat(1'b0, 16'h00B8, 16'h0040, 1'b1);
        expect_res(16'h3F80, 2'b00); beat(1'b0, 16'h0238, 16'h3838, 1'b1);
        expect_res(16'h3F82, 2'b00); beat(1'b0, 16'h0638, 16'h3838, 1'b1);
        expect_res(16'h4000, 2'b00); beat(1'b0, 16'h363E, 16'h2938, 1'b1);
        // Mode toggled mid-group is ignored: 1*1 + 1*1 in E4M3
        expect_res(16'h4000, 2'b00);
        beat(1'b0, 16'h0038, 16'h0038, 1'b0);
        beat(1'b1, 16'h0038, 16'h0038, 1'b1);
        drain();

        // Back-pressure: two results queued behind a blocked output
        bus.out_ready = 1'b0;
        expect_res(16'h3F80, 2'b00); beat(1'b1, 16'h003C, 16'h003C, 1'b1);
        expect_res(16'h4000, 2'b00); beat(1'b0, 16'h0038, 16'h0040, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("bp_in_ready",  32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Reset mid-group discards the partial sum
        beat(1'b0, 16'h3838, 16'h4040, 1'b0);
        beat(1'b0, 16'h3838, 16'h4040, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(bus.in_ready), 32'd0);
        check("mid_rst_out_data",  32'(bus.out_data), 32'd0);
        check("mid_rst_a_valid",   32'(bus.a_valid_out), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        // DEPTH beats with in_last on the last one: one clean result of 8.0
        expect_res(16'h4100, 2'b00);
        for (int i = 0; i < DEPTH - 1; i++) beat(1'b0, 16'h3838, 16'h3838, 1'b0);
        beat(1'b0, 16'h3838, 16'h3838, 1'b1);
        drain();
        repeat (8) @(posedge clk);
        #1;

        check("a_valid_pulses", 32'(n_pulse), 32'(n_acc));
        check("a_out_pending",  32'(aexp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, want completion", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fp8_dot_mac.md
Name: fp8_dot_mac

Overview:
- Parametrised successor to the single-operand FP8 MAC cell. Each accepted beat multiplies LANES pairs of FP8 operands (E4M3 or E5M2) and sums the products into an exact fixed-point accumulator.
- After DEPTH beats, or an earlier in_last beat, it emits one BF16 result through a ready/valid output register.
- The A operands are forwarded one cycle later for systolic chaining, as a PE column element of the array.

Parameters:
LANES, 2, FP8 operand pairs per beat (1..8)
DEPTH, 4, beats per accumulation group (2..256)
ACC_W, 80, signed accumulator width. LSB weight is 2^-32. Must be >= 65+clog2(LANES*DEPTH); elaboration assertion.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mode_fp8  in  1  0=E4M3, 1=E5M2; sampled on first beat of a group
in_valid  in  1  beat offered
in_ready  out  1  beat accepted when in_valid&&in_ready
in_last  in  1  closes the group on this beat
a_in  in  LANES*8  A operands, lane i at [8i+7:8i]
b_in  in  LANES*8  B operands
a_out  out  LANES*8  registered copy of a_in of last accepted beat
a_valid_out  out  1  one-cycle pulse, one cycle after each accepted beat
out_valid  out  1  result held in output register
out_ready  in  1  result consumed when out_valid&&out_ready
out_data  out  16  BF16 result
out_flags  out  2  [1]=NaN, [0]=Inf for the held result

Behaviour:
- Reset values: in_ready=0 during rst, 1 on first edge after release. a_out=0, a_valid_out=0, out_valid=0, out_data=0, out_flags=0. Accumulator, beat counter and FSM are cleared. Reset mid-group discards the group with no output.
- Decode, E4M3: bias 7, exp=0 is subnormal (eff exp -6), S.1111.111 is NaN, no Inf.
- Decode, E5M2: bias 15, exp=0 is subnormal (eff exp -14), exp=31 with mant=0 is Inf, otherwise NaN.
- Pipeline stage P (edge after accept): per lane, sign XOR, significand product (max 8 bits), shift to the 2^-32 grid. Lane sum is registered as signed. NaN/Inf flags registered: 0*Inf counts as NaN; Inf sign tracked.
- Stage A (next edge): acc += lane sum; NaN and Inf flags are sticky. +Inf and -Inf in one group produce NaN.
- Stage C (next edge): convert into the output register. Last beat accepted at edge N gives out_valid high after edge N+3 if the output register is free.
- Conversion precedence:
  - NaN gives 0x7FC0, flags=10.
  - Inf gives 0x7F80 or 0xFF80, flags=01.
  - acc==0 gives 0x0000 (never -0).
  - Otherwise sign-magnitude: leading-one position p (weight 2^(p-32)), exponent field = p-32+127. Round to 8 significand bits RNE on guard/sticky. A rounding carry increments the exponent.
  - BF16 subnormal and overflow cannot occur by construction.
- FSM:
  - ACC: in_ready=1. Counts beats. Goes to FLUSH on accept of the DEPTH-th beat or an in_last beat.
  - FLUSH: in_ready=0, 2 cycles while P/A drain. Then load the output register if !out_valid or out_ready this cycle, otherwise go to WAIT_OUT.
  - WAIT_OUT: in_ready=0. Loads when out_ready pops the old result; pop and load in the same cycle is allowed. Then returns to ACC with acc, counter and flags cleared.
- in_last on the DEPTH-th beat behaves as a single close. A 1-beat group is legal.
- out_data and out_flags are stable while out_valid&&!out_ready.
- Operands and mode are ignored when !in_valid. a_valid_out is independent of out_ready.

Decomposition:
- Package fp8_mac_pkg:
  - fmt_e enum (E4M3, E5M2)
  - BF16_QNAN, BF16_PINF, BF16_NINF constants
  - bias/exponent-range constants per format
  - function fp8_decode returning a struct {sign, sig[3:0], exp_eff, is_nan, is_inf, is_zero}
- Sub-module fp8_lane_mul: one lane's decode, multiply and alignment, instantiated LANES times.
- Conversion (leading-one detect + RNE) stays in the top.

Test Plan:
- E4M3, LANES=2, DEPTH=4: four beats of a={38,38}, b={40,40} -> one result 0x4180, flags=00, latency 3 cycles after 4th accept.
- E5M2 early close: beat a={3C,00}, b={3C,00}, in_last=1 -> 0x3F80. Then a={01,00}, b={01,00}, in_last=1 -> 0x2F80.
- Specials:
  - E5M2 a={7C,3C}, b={3C,3C} -> 0xFF80 not expected; 0x7F80, flags=01.
  - E5M2 a={00,..}, b={7C,..} -> 0x7FC0, flags=10.
  - E4M3 a={7F,..} -> 0x7FC0.
- Cancellation: E4M3 a={38,B8}, b={38,38}, in_last -> 0x0000. Mode toggled mid-group has no effect.
- Back-pressure: out_ready=0, send two 1-beat groups (results 0x3F80, 0x4000) -> in_ready stays 0 after second close until first pop. Results appear in order; out_data held stable.
- Reset mid-group after 2 beats -> no out_valid. Next group of DEPTH beats yields a correct, uncontaminated sum. a_valid_out pulses once per accept.
